// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory loader.
package mem_loader_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Number of host bytes that make up one memory word (memory word is 2*width bits).
    function automatic int unsigned calc_nbytes(input int unsigned width);
        return (2 * width) / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: first byte ends up as the MS byte.
module word_assembler
    import mem_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [BYTE_W-1:0]    byte_in,
    output logic [2*WIDTH-1:0]   word,
    output logic                 full,
    output logic                 last_c
);

    localparam int unsigned WORD_W = 2 * WIDTH;
    localparam int unsigned NBYTES = calc_nbytes(WIDTH);
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CNT_W-1:0] cnt;

    // The byte being shifted in now completes the word.
    assign last_c = (cnt == CNT_W'(NBYTES - 1));

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
            full <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
            full <= 1'b0;
        end else if (shift_en) begin
            word <= WORD_W'({word, byte_in});
            if (last_c) begin
                cnt  <= '0;
                full <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Host program loader sitting in front of the CPU's unified memory port.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                loadStart,
    input  logic                loadAbort,
    input  logic [ADDR_W-1:0]   loadBase,
    input  logic [ADDR_W-1:0]   loadLen,
    input  logic                byteValid,
    input  logic [BYTE_W-1:0]   byteData,
    output logic                byteReady,
    output logic                loading,
    output logic                loadDone,
    output logic [2*WIDTH-1:0]  loadChecksum,
    output logic                cpuStall,
    input  logic                cpuWrite,
    input  logic                cpuRead,
    input  logic [ADDR_W-1:0]   cpuAddress,
    input  logic [2*WIDTH-1:0]  cpuWriteData,
    output logic [2*WIDTH-1:0]  cpuReadData,
    output logic                memoryWrite,
    output logic                memoryRead,
    output logic [ADDR_W-1:0]   memoryAddress,
    output logic [2*WIDTH-1:0]  memoryWriteData,
    input  logic [2*WIDTH-1:0]  memoryOutData
);

    localparam int unsigned WORD_W = 2 * WIDTH;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   len;
    logic [ADDR_W-1:0]   word_cnt;
    logic [WORD_W-1:0]   asm_word;
    logic                asm_full;
    logic                asm_last_c;
    logic                asm_clear;
    logic                byte_acc;
    logic                last_word;

    // byteReady is only ever high in COLLECT, so it doubles as the state qualifier.
    assign byte_acc  = byteValid && byteReady && !loadAbort;
    // len of 0 wraps to 8'hFF, which gives the 256-word case for free.
    assign last_word = (word_cnt == ADDR_W'(len - ADDR_W'(1)));
    assign asm_clear = (state == IDLE) || (state == WRITE) || loadAbort;
    assign cpuStall  = loading;

    word_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (asm_clear),
        .shift_en (byte_acc),
        .byte_in  (byteData),
        .word     (asm_word),
        .full     (asm_full),
        .last_c   (asm_last_c)
    );

    // Loader FSM with registered status outputs, address/word counters and checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byteReady    <= 1'b0;
            loading      <= 1'b0;
            loadDone     <= 1'b0;
            loadChecksum <= '0;
            addr         <= '0;
            len          <= '0;
            word_cnt     <= '0;
        end else begin
            loadDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (loadStart && !loadAbort) begin
                        state        <= COLLECT;
                        addr         <= loadBase;
                        len          <= loadLen;
                        word_cnt     <= '0;
                        loadChecksum <= '0;
                        byteReady    <= 1'b1;
                        loading      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (loadAbort) begin
                        state     <= IDLE;
                        byteReady <= 1'b0;
                        loading   <= 1'b0;
                    end else if (byte_acc && asm_last_c) begin
                        state     <= WRITE;
                        byteReady <= 1'b0;
                    end
                end
                WRITE: begin
                    // The write on the port this cycle always lands, even when aborting.
                    addr         <= addr + ADDR_W'(1);
                    word_cnt     <= word_cnt + ADDR_W'(1);
                    loadChecksum <= loadChecksum ^ asm_word;
                    if (loadAbort) begin
                        state   <= IDLE;
                        loading <= 1'b0;
                    end else if (last_word) begin
                        state    <= DONE;
                        loadDone <= 1'b1;
                    end else begin
                        state     <= COLLECT;
                        byteReady <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    byteReady <= 1'b0;
                    loading   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    byteReady <= 1'b0;
                    loading   <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux: CPU passthrough in IDLE, loader owns the port otherwise.
    always_comb begin
        memoryWrite     = 1'b0;
        memoryRead      = 1'b0;
        memoryAddress   = addr;
        memoryWriteData = asm_word;
        cpuReadData     = '0;
        if (state == IDLE) begin
            memoryWrite     = cpuWrite;
            memoryRead      = cpuRead;
            memoryAddress   = cpuAddress;
            memoryWriteData = cpuWriteData;
            cpuReadData     = memoryOutData;
        end else if (state == WRITE) begin
            memoryWrite = asm_full;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader (WIDTH=8, 16-bit memory words).
module tb_mem_loader;

    logic        clk;
    logic        rst;
    logic        loadStart;
    logic        loadAbort;
    logic [7:0]  loadBase;
    logic [7:0]  loadLen;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        loading;
    logic        loadDone;
    logic [15:0] loadChecksum;
    logic        cpuStall;
    logic        cpuWrite;
    logic        cpuRead;
    logic [7:0]  cpuAddress;
    logic [15:0] cpuWriteData;
    logic [15:0] cpuReadData;
    logic        memoryWrite;
    logic        memoryRead;
    logic [7:0]  memoryAddress;
    logic [15:0] memoryWriteData;
    logic [15:0] memoryOutData;

    logic [15:0] mem [256];
    logic        mem_init;
    int          tests;
    int          fails;
    int          cycles;
    int          done_cnt;
    int          c0;
    int          d0;

    mem_loader #(.WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .loadStart       (loadStart),
        .loadAbort       (loadAbort),
        .loadBase        (loadBase),
        .loadLen         (loadLen),
        .byteValid       (byteValid),
        .byteData        (byteData),
        .byteReady       (byteReady),
        .loading         (loading),
        .loadDone        (loadDone),
        .loadChecksum    (loadChecksum),
        .cpuStall        (cpuStall),
        .cpuWrite        (cpuWrite),
        .cpuRead         (cpuRead),
        .cpuAddress      (cpuAddress),
        .cpuWriteData    (cpuWriteData),
        .cpuReadData     (cpuReadData),
        .memoryWrite     (memoryWrite),
        .memoryRead      (memoryRead),
        .memoryAddress   (memoryAddress),
        .memoryWriteData (memoryWriteData),
        .memoryOutData   (memoryOutData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fill with 0xC000|addr, then synchronous write, async read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
        end else if (memoryWrite) begin
            mem[memoryAddress] <= memoryWriteData;
        end
    end
    assign memoryOutData = mem[memoryAddress];

    // Count every loadDone cycle seen.
    always @(negedge clk) if (loadDone) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
        if (cycles > 20000) begin
            $display("FAIL timeout observed=%0d cycles expected<=20000", cycles);
            $fatal(1, "bench timeout");
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until the loader takes it.
    task automatic feed(input logic [7:0] b, input int gap);
        int g;
        if (gap > 0) begin
            byteValid = 1'b0;
            repeat (gap) tick();
        end
        byteData  = b;
        byteValid = 1'b1;
        g = 0;
        while (!byteReady && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) chk("feed_timeout", 32'(g), 32'd0);
        tick();
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!loadDone && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("done_timeout", 32'(g), 32'd0);
    endtask

    task automatic start_load(input logic [7:0] base, input logic [7:0] len);
        loadBase  = base;
        loadLen   = len;
        loadStart = 1'b1;
        c0 = cycles;
        tick();
        loadStart = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [15:0] d);
        cpuWrite = 1'b1; cpuAddress = a; cpuWriteData = d;
        tick();
        cpuWrite = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; cycles = 0; done_cnt = 0;
        rst = 1'b1; mem_init = 1'b1;
        loadStart = 0; loadAbort = 0; loadBase = 0; loadLen = 0;
        byteValid = 0; byteData = 0;
        cpuWrite = 0; cpuRead = 0; cpuAddress = 0; cpuWriteData = 0;
        tick(); tick();
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_byteReady", 32'(byteReady), 32'd0);
        chk("rst_loadDone", 32'(loadDone), 32'd0);
        chk("rst_checksum", 32'(loadChecksum), 32'd0);
        chk("rst_cpuStall", 32'(cpuStall), 32'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        tick();

        // 1: passthrough in IDLE
        cpuWrite = 1'b1; cpuAddress = 8'h10; cpuWriteData = 16'hBEEF;
        #1;
        chk("pt_memWrite", 32'(memoryWrite), 32'd1);
        chk("pt_memAddr", 32'(memoryAddress), 32'h10);
        chk("pt_memWData", 32'(memoryWriteData), 32'hBEEF);
        tick();
        cpuWrite = 1'b0; cpuRead = 1'b1;
        #1;
        chk("pt_memRead", 32'(memoryRead), 32'd1);
        chk("pt_readData", 32'(cpuReadData), 32'hBEEF);
        chk("pt_loading", 32'(loading), 32'd0);
        tick();
        cpuRead = 1'b0;

        // 2: full-rate load of three words; CPU hammers the port meanwhile
        start_load(8'h20, 8'd3);
        cpuWrite = 1'b1; cpuRead = 1'b1; cpuAddress = 8'h30; cpuWriteData = 16'hFFFF;
        #1;
        chk("s2_loading", 32'(loading), 32'd1);
        chk("s2_stall", 32'(cpuStall), 32'd1);
        chk("s2_byteReady", 32'(byteReady), 32'd1);
        chk("s2_memWrite_collect", 32'(memoryWrite), 32'd0);
        chk("s2_memRead_collect", 32'(memoryRead), 32'd0);
        chk("s2_cpuReadData", 32'(cpuReadData), 32'd0);
        feed(8'h12, 0); feed(8'h34, 0); feed(8'h56, 0);
        feed(8'h78, 0); feed(8'h9A, 0); feed(8'hBC, 0);
        byteValid = 1'b0;
        wait_done();
        chk("s2_done", 32'(loadDone), 32'd1);
        chk("s2_latency", 32'(cycles - c0), 32'd10);
        chk("s2_done_loading", 32'(loading), 32'd1);
        chk("s2_checksum", 32'(loadChecksum), 32'hDEF0);
        cpuWrite = 1'b0; cpuRead = 1'b0;
        tick();
        chk("s2_done_pulse", 32'(loadDone), 32'd0);
        chk("s2_idle", 32'(loading), 32'd0);
        chk("s2_mem20", 32'(mem[8'h20]), 32'h1234);
        chk("s2_mem21", 32'(mem[8'h21]), 32'h5678);
        chk("s2_mem22", 32'(mem[8'h22]), 32'h9ABC);
        chk("s2_mem23", 32'(mem[8'h23]), 32'hC023);
        chk("s2_mem30_cpu_ignored", 32'(mem[8'h30]), 32'hC030);
        chk("s2_checksum_held", 32'(loadChecksum), 32'hDEF0);

        // 3: address wrap 0xFF -> 0x00
        start_load(8'hFF, 8'd2);
        feed(8'hAA, 0); feed(8'h55, 0); feed(8'h11, 0); feed(8'h22, 0);
        byteValid = 1'b0;
        wait_done();
        chk("s3_checksum", 32'(loadChecksum), 32'hBB77);
        tick();
        chk("s3_memFF", 32'(mem[8'hFF]), 32'hAA55);
        chk("s3_mem00", 32'(mem[8'h00]), 32'h1122);
        chk("s3_mem01", 32'(mem[8'h01]), 32'hC001);

        // 4: backpressure with random gaps and a byte held across WRITE
        cpu_wr(8'h20, 16'h0000); cpu_wr(8'h21, 16'h0000); cpu_wr(8'h22, 16'h0000);
        start_load(8'h20, 8'd3);
        feed(8'h12, int'($urandom_range(0, 3)));
        feed(8'h34, int'($urandom_range(0, 3)));
        byteData = 8'h56; byteValid = 1'b1;
        #1;
        chk("s4_write_byteReady", 32'(byteReady), 32'd0);
        chk("s4_write_memWrite", 32'(memoryWrite), 32'd1);
        chk("s4_write_addr", 32'(memoryAddress), 32'h20);
        chk("s4_write_data", 32'(memoryWriteData), 32'h1234);
        feed(8'h56, 0);
        feed(8'h78, int'($urandom_range(1, 3)));
        feed(8'h9A, int'($urandom_range(0, 3)));
        feed(8'hBC, int'($urandom_range(1, 3)));
        byteValid = 1'b0;
        wait_done();
        chk("s4_checksum", 32'(loadChecksum), 32'hDEF0);
        tick();
        chk("s4_mem20", 32'(mem[8'h20]), 32'h1234);
        chk("s4_mem21", 32'(mem[8'h21]), 32'h5678);
        chk("s4_mem22", 32'(mem[8'h22]), 32'h9ABC);

        // 5: mid-load start is ignored, abort after three bytes
        d0 = done_cnt;
        start_load(8'h40, 8'd2);
        feed(8'h11, 0);
        loadStart = 1'b1; loadBase = 8'h80; loadLen = 8'd5;
        feed(8'h22, 0);
        loadStart = 1'b0;
        feed(8'h33, 0);
        byteValid = 1'b0;
        chk("s5_still_loading", 32'(loading), 32'd1);
        loadAbort = 1'b1;
        tick();
        loadAbort = 1'b0;
        chk("s5_abort_loading", 32'(loading), 32'd0);
        chk("s5_abort_byteReady", 32'(byteReady), 32'd0);
        chk("s5_mem40", 32'(mem[8'h40]), 32'h1122);
        chk("s5_mem41", 32'(mem[8'h41]), 32'hC041);
        chk("s5_mem80", 32'(mem[8'h80]), 32'hC080);
        chk("s5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("s5_checksum_partial", 32'(loadChecksum), 32'h1122);
        cpu_wr(8'h41, 16'h5A5A);
        cpuRead = 1'b1; cpuAddress = 8'h41;
        #1;
        chk("s5_cpu_read", 32'(cpuReadData), 32'h5A5A);
        cpuRead = 1'b0;
        loadStart = 1'b1; loadAbort = 1'b1;
        tick();
        loadStart = 1'b0; loadAbort = 1'b0;
        chk("s5_start_abort_idle", 32'(loading), 32'd0);
        start_load(8'h42, 8'd1);
        feed(8'h77, 0); feed(8'h88, 0);
        byteValid = 1'b0;
        wait_done();
        tick();
        chk("s5_mem42_fresh", 32'(mem[8'h42]), 32'h7788);
        chk("s5_checksum_fresh", 32'(loadChecksum), 32'h7788);

        // 6: async reset mid-COLLECT, then a fresh single-word load
        start_load(8'h60, 8'd1);
        feed(8'hCA, 0);
        byteValid = 1'b0;
        chk("s6_pre_loading", 32'(loading), 32'd1);
        rst = 1'b1;
        #1;
        chk("s6_rst_loading", 32'(loading), 32'd0);
        chk("s6_rst_byteReady", 32'(byteReady), 32'd0);
        chk("s6_rst_checksum", 32'(loadChecksum), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("s6_post_loading", 32'(loading), 32'd0);
        chk("s6_mem60_untouched", 32'(mem[8'h60]), 32'hC060);
        start_load(8'h60, 8'd1);
        feed(8'hCA, 0); feed(8'hFE, 0);
        byteValid = 1'b0;
        wait_done();
        chk("s6_done", 32'(loadDone), 32'd1);
        chk("s6_checksum", 32'(loadChecksum), 32'hCAFE);
        tick();
        chk("s6_mem60", 32'(mem[8'h60]), 32'hCAFE);
        chk("s6_mem61", 32'(mem[8'h61]), 32'hC061);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
